// File: rtl/quant_bank_ctrl.sv
// Double-buffered quantizer table loader with frame-synchronous bank and geometry swap.
// Optional QUANT_BANK_CHECKSUM_EN adds a running 16-bit sum of loaded coefficients.
module quant_bank_ctrl #(
  parameter int M_BITS        = 13,
  parameter int SENSOR_X_SIZE = 1280,
  parameter int SENSOR_Y_SIZE = 720,
  localparam int XW = $clog2(SENSOR_X_SIZE),
  localparam int YW = $clog2(SENSOR_Y_SIZE)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_start,
  input  logic [2*M_BITS-1:0] tbl_data,
  input  logic              tbl_valid,
  output logic              tbl_ready,
  input  logic [XW-1:0]     new_x_size_m1,
  input  logic [YW-1:0]     new_y_size_m1,
  input  logic              frame_end,
  output logic              wr_en,
  output logic [6:0]        wr_addr,
  output logic [2*M_BITS-1:0] wr_data,
  output logic              active_bank,
  output logic [XW-1:0]     x_size_m1,
  output logic [YW-1:0]     y_size_m1,
  output logic              busy,
  output logic              swap_done,
`ifdef QUANT_BANK_CHECKSUM_EN
  output logic [15:0]       tbl_sum,
`endif
  output logic              load_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] ARMED = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [5:0]          idx_q, idx_d;
  logic                bank_q, bank_d;
  logic [XW-1:0]       shx_q, shx_d, x_q, x_d;
  logic [YW-1:0]       shy_q, shy_d, y_q, y_d;
  logic                wr_en_q, wr_en_d;
  logic [6:0]          wr_addr_q, wr_addr_d;
  logic [2*M_BITS-1:0] wr_data_q, wr_data_d;
  logic                swap_q, swap_d;
  logic                err_q, err_d;
  logic [15:0]         sum_q, sum_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bank_d    = bank_q;
    shx_d     = shx_q;
    shy_d     = shy_q;
    x_d       = x_q;
    y_d       = y_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    swap_d    = 1'b0;
    err_d     = err_q;
    sum_d     = sum_q;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          idx_d   = 6'd0;
          shx_d   = new_x_size_m1;
          shy_d   = new_y_size_m1;
          sum_d   = 16'd0;
        end
      end
      LOAD: begin
        if (load_start) err_d = 1'b1;
        if (tbl_valid) begin
          // Writes always target the bank the quantizer is not reading.
          wr_en_d   = 1'b1;
          wr_addr_d = {~bank_q, idx_q};
          wr_data_d = tbl_data;
          idx_d     = idx_q + 6'd1;
          sum_d     = sum_q + 16'(tbl_data[M_BITS-1:0]) + 16'(tbl_data[2*M_BITS-1:M_BITS]);
          if (idx_q == 6'd63) state_d = ARMED;
        end
      end
      ARMED: begin
        if (load_start) err_d = 1'b1;
        if (frame_end) begin
          state_d = IDLE;
          bank_d  = ~bank_q;
          x_d     = shx_q;
          y_d     = shy_q;
          swap_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      idx_q     <= 6'd0;
      bank_q    <= 1'b0;
      shx_q     <= XW'(SENSOR_X_SIZE - 1);
      shy_q     <= YW'(SENSOR_Y_SIZE - 1);
      x_q       <= XW'(SENSOR_X_SIZE - 1);
      y_q       <= YW'(SENSOR_Y_SIZE - 1);
      wr_en_q   <= 1'b0;
      wr_addr_q <= 7'd0;
      wr_data_q <= '0;
      swap_q    <= 1'b0;
      err_q     <= 1'b0;
      sum_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bank_q    <= bank_d;
      shx_q     <= shx_d;
      shy_q     <= shy_d;
      x_q       <= x_d;
      y_q       <= y_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      swap_q    <= swap_d;
      err_q     <= err_d;
      sum_q     <= sum_d;
    end
  end

  assign tbl_ready   = (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign active_bank = bank_q;
  assign x_size_m1   = x_q;
  assign y_size_m1   = y_q;
  assign swap_done   = swap_q;
  assign load_err    = err_q;
`ifdef QUANT_BANK_CHECKSUM_EN
  assign tbl_sum     = sum_q;
`else
  logic unusedSum;
  assign unusedSum   = ^sum_q;
`endif

endmodule

// File: doc/quant_bank_ctrl.md
# quant_bank_ctrl

Double-buffered quantizer table and geometry controller for the JPEG encoder. Accepts a new set of reciprocal quantizer coefficients from the host as a valid/ready stream. Writes them into the inactive bank of the two-bank quantizer table RAM. At the next frame boundary it swaps the active bank and the frame geometry in the same cycle, so a frame is never quantized with mixed tables or a mixed size.

## Interface
Parameters:
- M_BITS, 13, width of one reciprocal coefficient.
- SENSOR_X_SIZE, 1280, maximum width; sets the x geometry width.
- SENSOR_Y_SIZE, 720, maximum height; sets the y geometry width.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- load_start  in  1  pulse: begin a table load into the inactive bank.
- tbl_data  in  2*M_BITS  coefficient pair, {odd, even}, zigzag order; pairs 0..31 luma, 32..63 chroma.
- tbl_valid  in  1  tbl_data valid.
- tbl_ready  out  1  high only in LOAD.
- new_x_size_m1  in  $clog2(SENSOR_X_SIZE)  pending width-1, captured at load_start.
- new_y_size_m1  in  $clog2(SENSOR_Y_SIZE)  pending height-1, captured at load_start.
- frame_end  in  1  pulse: last coefficient pair of a frame accepted at the quantizer input.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  7  {bank, pair index[5:0]}.
- wr_data  out  2*M_BITS  RAM write data.
- active_bank  out  1  bank the quantizer reads; forms the read-address MSB.
- x_size_m1  out  $clog2(SENSOR_X_SIZE)  active geometry.
- y_size_m1  out  $clog2(SENSOR_Y_SIZE)  active geometry.
- busy  out  1  state != IDLE.
- swap_done  out  1  one-cycle pulse on bank swap.
- load_err  out  1  sticky; set when load_start arrives outside IDLE.

## Operation
- States: IDLE, LOAD, ARMED.
- IDLE -> LOAD on load_start. Capture new_x/new_y into shadow registers and clear idx.
- LOAD: each cycle with tbl_valid & tbl_ready, drive a write of tbl_data to {~active_bank, idx} and increment idx. The beat with idx==63 moves to ARMED.
- ARMED: on frame_end, toggle active_bank, copy shadow geometry to x_size_m1/y_size_m1, pulse swap_done, and go to IDLE.
- frame_end in IDLE or LOAD: ignored, no state change. A partially loaded bank is never activated.
- load_start in LOAD or ARMED: ignored and sets load_err. The load in progress is unaffected.
- load_err clears only on reset.
- The active bank is never written; the write MSB is always ~active_bank.
- No arithmetic on coefficients; data passes through unchanged.

## Timing
- Reset values:
  - state IDLE, active_bank 0, idx 0.
  - wr_en 0, wr_addr 0, wr_data 0, tbl_ready 0.
  - swap_done 0, busy 0, load_err 0.
  - x_size_m1 = SENSOR_X_SIZE-1, y_size_m1 = SENSOR_Y_SIZE-1.
- tbl_ready rises the cycle after load_start.
- Write outputs are registered: wr_en/wr_addr/wr_data appear one cycle after the accepted beat.
- A full load takes at least 64 cycles. tbl_valid gaps stall the load indefinitely.
- Swap: in the cycle after frame_end is sampled in ARMED, the following change together: active_bank, x_size_m1/y_size_m1, swap_done=1, state IDLE.
  - The quantizer's first read of the next frame therefore sees the new bank.
  - frame_end is guaranteed at least 2 cycles before the next frame's first pair.
- The 64th beat and frame_end in the same cycle: the state is still LOAD, so no swap occurs. The swap waits for the following frame_end.
- load_start coincident with swap_done: the state is already IDLE, so the new load is accepted.
- Reset mid-LOAD discards the partial load. The active bank reverts to 0; RAM contents are not cleared.

## Configuration
- QUANT_BANK_CHECKSUM_EN defined:
  - Adds a 16-bit output tbl_sum, the modulo-2^16 sum of both M_BITS halves of every accepted beat.
  - tbl_sum is cleared at load_start and frozen in ARMED and IDLE.
  - Reset value 0.
- Undefined: port and logic are absent; all other behaviour is identical.

## Test plan
- Reset, then idle 10 cycles:
  - active_bank=0, x_size_m1=1279, y_size_m1=719.
  - busy=0, wr_en=0.
- Load start, then 64 beats with data=idx, then frame_end:
  - 64 writes to addr 64..127.
  - swap_done one cycle after frame_end; active_bank=1.
  - Geometry = captured 639/479.
- Second load after that swap:
  - Writes go to addr 0..63.
  - Next frame_end returns active_bank to 0.
- frame_end during beat 30 of a load:
  - No swap, active_bank unchanged, busy stays 1.
  - The later frame_end after completion swaps.
- Random tbl_valid gaps, plus load_start while ARMED:
  - Exactly 64 writes.
  - load_err=1 sticky; swap still occurs on frame_end.
- With QUANT_BANK_CHECKSUM_EN, all 64 beats = {13'd1, 13'd2}:
  - tbl_sum=192 after load.
  - tbl_sum resets to 0 on the next load_start.
